// File: rtl/packet_rx_sequencer.sv
// Frames SYNC,HDR,D1,D2,CHK command packets from a byte-strobe stream and commits PORT1/PORT2 on a good check.
// Commit/error latency 1 cycle from the final strobe; no backpressure, every strobe is consumed, stalls time out.
module packet_rx_sequencer #(
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES  = 50000,
  parameter int         LED_HOLD_CYCLES = 5000000,
  parameter int         CNT_W           = 23
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic [7:0] PORT1,
  output logic [7:0] PORT2,
  output logic       PORT_UPDATE,
  output logic       LED_OK,
  output logic       LED_ERR,
  output logic [1:0] ERR_CODE,
  output logic [7:0] ERR_COUNT,
  output logic       BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_D1, S_D2, S_CHK} state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LED_LOAD = CNT_W'(LED_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_mask;
  logic [7:0]       r_d1;
  logic [7:0]       r_d2;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [7:0]       r_port1;
  logic [7:0]       r_port2;
  logic             r_port_update;
  logic [1:0]       r_err_code;
  logic [7:0]       r_err_count;

  logic             w_timeout;
  logic             w_hdr_bad;
  logic             w_good;
  logic             w_err;
  logic [1:0]       w_code;

  // A byte in the expiry cycle wins over the timeout.
  assign w_timeout = (r_state != S_IDLE) && !BYTE_VALID && (r_to_cnt == TO_LAST);
  assign w_hdr_bad = (BYTE_IN[7:2] != 6'd0) || (BYTE_IN[1:0] == 2'd0);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (BYTE_VALID) begin
      case (r_state)
        S_IDLE:  if (BYTE_IN == SYNC_BYTE) w_next = S_HDR;
        S_HDR:   w_next = w_hdr_bad ? S_IDLE : S_D1;
        S_D1:    w_next = S_D2;
        S_D2:    w_next = S_CHK;
        S_CHK:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_good = 1'b0;
    w_err  = 1'b0;
    w_code = 2'd0;
    if (w_timeout) begin
      w_err  = 1'b1;
      w_code = 2'd3;
    end else if (BYTE_VALID) begin
      if (r_state == S_HDR && w_hdr_bad) begin
        w_err  = 1'b1;
        w_code = 2'd1;
      end else if (r_state == S_CHK) begin
        if (BYTE_IN == (r_mask ^ r_d1 ^ r_d2)) begin
          w_good = 1'b1;
        end else begin
          w_err  = 1'b1;
          w_code = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mask        <= 8'd0;
      r_d1          <= 8'd0;
      r_d2          <= 8'd0;
      r_to_cnt      <= '0;
      r_ok_cnt      <= '0;
      r_err_cnt     <= '0;
      r_port1       <= 8'd0;
      r_port2       <= 8'd0;
      r_port_update <= 1'b0;
      r_err_code    <= 2'd0;
      r_err_count   <= 8'd0;
    end else begin
      if (BYTE_VALID) begin
        if (r_state == S_HDR) r_mask <= BYTE_IN;
        if (r_state == S_D1)  r_d1   <= BYTE_IN;
        if (r_state == S_D2)  r_d2   <= BYTE_IN;
      end

      if (r_state == S_IDLE || BYTE_VALID || w_timeout) r_to_cnt <= '0;
      else                                              r_to_cnt <= r_to_cnt + CNT_ONE;

      r_port_update <= w_good;
      if (w_good) begin
        if (r_mask[0]) r_port1 <= r_d1;
        if (r_mask[1]) r_port2 <= r_d2;
        r_err_code <= 2'd0;
        r_ok_cnt   <= LED_LOAD;
      end else if (r_ok_cnt != '0) begin
        r_ok_cnt <= r_ok_cnt - CNT_ONE;
      end

      if (w_err) begin
        r_err_code <= w_code;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        r_err_cnt <= LED_LOAD;
      end else if (r_err_cnt != '0) begin
        r_err_cnt <= r_err_cnt - CNT_ONE;
      end
    end
  end

  assign PORT1       = r_port1;
  assign PORT2       = r_port2;
  assign PORT_UPDATE = r_port_update;
  assign LED_OK      = (r_ok_cnt != '0);
  assign LED_ERR     = (r_err_cnt != '0);
  assign ERR_CODE    = r_err_code;
  assign ERR_COUNT   = r_err_count;
  assign BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_packet_rx_sequencer.sv
// Directed bench for packet_rx_sequencer: per-cycle vector table plus hand-written timeout, reset and saturation sequences.
module tb_packet_rx_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] BYTE_IN = 8'h00;
  logic       BYTE_VALID = 1'b0;
  logic [7:0] PORT1;
  logic [7:0] PORT2;
  logic       PORT_UPDATE;
  logic       LED_OK;
  logic       LED_ERR;
  logic [1:0] ERR_CODE;
  logic [7:0] ERR_COUNT;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  packet_rx_sequencer #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(16),
    .LED_HOLD_CYCLES(8),
    .CNT_W(23)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .PORT1(PORT1),
    .PORT2(PORT2),
    .PORT_UPDATE(PORT_UPDATE),
    .LED_OK(LED_OK),
    .LED_ERR(LED_ERR),
    .ERR_CODE(ERR_CODE),
    .ERR_COUNT(ERR_COUNT),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       vld;
    logic [7:0] b;
    logic       busy;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       upd;
    logic       lok;
    logic       lerr;
    logic [1:0] code;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic [7:0] b, input logic busy,
                     input logic [7:0] p1, input logic [7:0] p2, input logic upd,
                     input logic lok, input logic lerr, input logic [1:0] code,
                     input logic [7:0] cnt);
    vec_t v;
    v.vld = vld; v.b = b; v.busy = busy; v.p1 = p1; v.p2 = p2; v.upd = upd;
    v.lok = lok; v.lerr = lerr; v.code = code; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then sample just after the rising edge.
  task automatic step(input logic vld, input logic [7:0] b);
    BYTE_VALID = vld;
    BYTE_IN    = vld ? b : 8'h00;
    @(posedge CLK);
    #1;
    BYTE_VALID = 1'b0;
    BYTE_IN    = 8'h00;
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    step(1'b1, b0); step(1'b1, b1); step(1'b1, b2); step(1'b1, b3); step(1'b1, b4);
  endtask

  function automatic logic [29:0] pack_out();
    return {BUSY, PORT1, PORT2, PORT_UPDATE, LED_OK, LED_ERR, ERR_CODE, ERR_COUNT};
  endfunction

  initial begin
    int  n;
    logic held;

    // Good packet, back-to-back bytes.
    add(1, 8'hA5, 1, 8'h00, 8'h00, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'h03, 1, 8'h00, 8'h00, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'h12, 1, 8'h00, 8'h00, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'h34, 1, 8'h00, 8'h00, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'h25, 0, 8'h12, 8'h34, 1, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 0, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    // Port1-only packet with 3 idle cycles between bytes; LED_OK runs out on the way.
    add(1, 8'hA5, 1, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(1, 8'h01, 1, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'h5A, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'hFF, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(0, 8'h00, 1, 8'h12, 8'h34, 0, 0, 0, 2'd0, 8'd0);
    add(1, 8'hA4, 0, 8'h5A, 8'h34, 1, 1, 0, 2'd0, 8'd0);
    add(0, 8'h00, 0, 8'h5A, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    // Bad check byte.
    add(1, 8'hA5, 1, 8'h5A, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(1, 8'h03, 1, 8'h5A, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(1, 8'h12, 1, 8'h5A, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(1, 8'h34, 1, 8'h5A, 8'h34, 0, 1, 0, 2'd0, 8'd0);
    add(1, 8'h24, 0, 8'h5A, 8'h34, 0, 1, 1, 2'd2, 8'd1);
    // Junk ignored in IDLE, then a bad header.
    add(1, 8'h00, 0, 8'h5A, 8'h34, 0, 1, 1, 2'd2, 8'd1);
    add(1, 8'h11, 0, 8'h5A, 8'h34, 0, 0, 1, 2'd2, 8'd1);
    add(1, 8'hA5, 1, 8'h5A, 8'h34, 0, 0, 1, 2'd2, 8'd1);
    add(1, 8'h07, 0, 8'h5A, 8'h34, 0, 0, 1, 2'd1, 8'd2);

    RST = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    RST = 1'b0;
    chk("reset_state", 32'(pack_out()), 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].b);
      chk($sformatf("vec_row_%0d", i), 32'(pack_out()),
          32'({tbl[i].busy, tbl[i].p1, tbl[i].p2, tbl[i].upd, tbl[i].lok,
               tbl[i].lerr, tbl[i].code, tbl[i].cnt}));
    end

    // Stall after HDR: timeout expected exactly 16 idle cycles later.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    n = 0;
    while (BUSY && n < 40) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("timeout_code", 32'(ERR_CODE), 32'd3);
    chk("timeout_count", 32'(ERR_COUNT), 32'd3);

    // D1 lands in the expiry cycle: byte wins, FSM continues to D2.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    repeat (15) step(1'b0, 8'h00);
    step(1'b1, 8'h12);
    chk("expiry_byte_busy", 32'(BUSY), 32'd1);
    chk("expiry_byte_count", 32'(ERR_COUNT), 32'd3);
    step(1'b1, 8'h34);
    step(1'b1, 8'h25);
    chk("expiry_commit", 32'({PORT_UPDATE, PORT1, PORT2, ERR_CODE}), 32'({1'b1, 8'h12, 8'h34, 2'd0}));

    // Reset while in D2 discards the partial packet.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    step(1'b1, 8'h12);
    chk("pre_reset_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    step(1'b0, 8'h00);
    RST = 1'b0;
    chk("mid_reset_state", 32'(pack_out()), 32'd0);
    send5(8'hA5, 8'h03, 8'h12, 8'h34, 8'h25);
    chk("post_reset_commit", 32'(pack_out()),
        32'({1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0}));

    // 260 bad-check packets: counter saturates, LED_ERR never drops.
    held = 1'b1;
    send5(8'hA5, 8'h03, 8'h12, 8'h34, 8'h24);
    for (int k = 1; k < 260; k++) begin
      for (int j = 0; j < 5; j++) begin
        step(1'b1, (j == 0) ? 8'hA5 : (j == 1) ? 8'h03 : (j == 2) ? 8'h12 : (j == 3) ? 8'h34 : 8'h24);
        if (!LED_ERR) held = 1'b0;
      end
    end
    chk("sat_count", 32'(ERR_COUNT), 32'hFF);
    chk("sat_code_ports", 32'({ERR_CODE, PORT1, PORT2}), 32'({2'd2, 8'h12, 8'h34}));
    chk("led_err_held", 32'(held), 32'd1);
    repeat (7) step(1'b0, 8'h00);
    chk("led_err_tail_7", 32'(LED_ERR), 32'd1);
    step(1'b0, 8'h00);
    chk("led_err_tail_8", 32'(LED_ERR), 32'd0);
    chk("final_idle", 32'({BUSY, PORT_UPDATE}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
